// File: rtl/counter_defs.sv
// rtl/counter_defs.sv - shared direction and mode constants for counter blocks
package counter_defs;

  localparam bit DIR_UP    = 1'b1;
  localparam bit DIR_DOWN  = 1'b0;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with clear, load, wrap/saturate
// and a combinational terminal count for cascading.
module updown_mod_counter
  import counter_defs::*;
#(
  parameter int    WIDTH    = 4,
  parameter longint MAX     = (longint'(1) << WIDTH) - 1,
  parameter longint RST_VAL = 0,
  parameter int    SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be 1..32");
  end
  if (MAX < 1 || MAX > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("updown_mod_counter: MAX must be 1..2**WIDTH-1");
  end
  if (RST_VAL < 0 || RST_VAL > MAX) begin : g_bad_rst
    $error("updown_mod_counter: RST_VAL must be 0..MAX");
  end

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RST_VAL);
  localparam bit               SAT_MODE = (SATURATE == int'(MODE_SAT));

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  // Returns {bound_hit, next_value}; explicit compares keep q within 0..MAX
  // even when MAX is not a power of two minus one.
  function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur,
                                                input logic             dir);
    logic [WIDTH-1:0] nxt;
    logic             hit;
    nxt = cur;
    hit = 1'b0;
    if (dir == DIR_UP) begin
      if (cur < MAX_V) begin
        nxt = cur + WIDTH'(1);
      end else begin
        hit = 1'b1;
        nxt = SAT_MODE ? cur : '0;
      end
    end else begin
      if (cur != '0) begin
        nxt = cur - WIDTH'(1);
      end else begin
        hit = 1'b1;
        nxt = SAT_MODE ? cur : MAX_V;
      end
    end
    return {hit, nxt};
  endfunction

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      {wrap_d, q_d} = next_count(q_q, up);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = en & (((up == DIR_UP) & (q_q == MAX_V)) |
                      ((up == DIR_DOWN) & (q_q == '0)));

endmodule
